// File: rtl/output_requant_collector.sv
// Output requantizer and result collector.
// Accepts tagged accumulator values from the MAC array, rounds/shifts/clamps
// them to OUT_WIDTH, queues them in a show-ahead FIFO and streams them out on
// a ready/valid interface. Pulses done once a full feature map has been sent.
module output_requant_collector #(
    parameter int ACC_WIDTH          = 32,
    parameter int OUT_WIDTH          = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int FIFO_DEPTH         = 8,
    localparam int X_W  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
    localparam int Y_W  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
    localparam int CH_W = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [4:0]                  cfg_shift,
    input  logic                        cfg_relu,
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic                        acc_valid,
    input  logic [X_W-1:0]              acc_x,
    input  logic [Y_W-1:0]              acc_y,
    input  logic [CH_W-1:0]             acc_ch,
    output logic                        almost_full,
    output logic signed [OUT_WIDTH-1:0] res_data,
    output logic [X_W-1:0]              res_x,
    output logic [Y_W-1:0]              res_y,
    output logic [CH_W-1:0]             res_ch,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic                        protocol_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W+1:0] AF_THR  = (PTR_W+2)'(FIFO_DEPTH - 2);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Round-half-up then arithmetic shift; one guard bit keeps the rounding add from wrapping.
    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic [4:0]                  sh
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = '0;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        return (ext + rnd) >>> sh;
    endfunction

    // Optional ReLU followed by clamping to the signed output range.
    function automatic logic signed [OUT_WIDTH-1:0] saturate(
        input logic signed [ACC_WIDTH:0] r,
        input logic                      relu
    );
        logic signed [ACC_WIDTH:0] v;
        v = r;
        if (relu && v[ACC_WIDTH]) v = '0;
        if (v > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        else                  return v[OUT_WIDTH-1:0];
    endfunction

    state_t                        state_q, state_d;
    logic [4:0]                    cfg_shift_q;
    logic                          cfg_relu_q;
    logic [CNT_W-1:0]              acc_count, cnt_next;
    logic                          vld_p1;
    logic signed [ACC_WIDTH-1:0]   acc_p1;
    logic [X_W-1:0]                x_p1;
    logic [Y_W-1:0]                y_p1;
    logic [CH_W-1:0]               ch_p1;
    logic signed [OUT_WIDTH-1:0]   res_p2;
    logic signed [OUT_WIDTH-1:0]   data_mem [FIFO_DEPTH];
    logic [X_W-1:0]                x_mem    [FIFO_DEPTH];
    logic [Y_W-1:0]                y_mem    [FIFO_DEPTH];
    logic [CH_W-1:0]               ch_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [PTR_W:0]                count;
    logic                          full, pop, do_push;
    logic [PTR_W+1:0]              occupancy;

    // S1 valid: only values arriving while running enter the pipeline.
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= acc_valid && (state_q == S_RUN);
    end

    // S1 data capture (no reset; qualified by vld_p1 downstream).
    always_ff @(posedge clk) begin
        if (acc_valid) begin
            acc_p1 <= acc_in;
            x_p1   <= acc_x;
            y_p1   <= acc_y;
            ch_p1  <= acc_ch;
        end
    end

    // ---- S1 -> S2: requantize and write into the FIFO ----
    always_comb begin
        res_p2  = saturate(round_shift(acc_p1, cfg_shift_q), cfg_relu_q);
        full    = (count == DEPTH_C);
        res_valid = (count != '0);
        pop     = res_valid && res_ready;
        do_push = vld_p1 && (!full || pop);
        occupancy = {1'b0, count} + {{(PTR_W+1){1'b0}}, vld_p1};
        almost_full = (occupancy >= AF_THR);
        res_data = res_valid ? data_mem[rd_ptr] : '0;
        res_x    = res_valid ? x_mem[rd_ptr]    : '0;
        res_y    = res_valid ? y_mem[rd_ptr]    : '0;
        res_ch   = res_valid ? ch_mem[rd_ptr]   : '0;
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= res_p2;
            x_mem[wr_ptr]    <= x_p1;
            y_mem[wr_ptr]    <= y_p1;
            ch_mem[wr_ptr]   <= ch_p1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (vld_p1 && full && !pop) overflow <= 1'b1;
        end
    end

    // Next-state and status outputs; DONE is entered in the cycle after the last accept.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        cnt_next = acc_count + {{(CNT_W-1){1'b0}}, (pop && state_q == S_RUN)};
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_next == TOTAL_C) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, configuration latch, delivered-output counter, protocol flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cfg_shift_q  <= '0;
            cfg_relu_q   <= 1'b0;
            acc_count    <= '0;
            protocol_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                cfg_shift_q <= cfg_shift;
                cfg_relu_q  <= cfg_relu;
                acc_count   <= '0;
            end else if (state_q == S_RUN) begin
                acc_count <= cnt_next;
            end
            if (acc_valid && state_q != S_RUN) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_requant_collector.sv
// Scoreboard bench for output_requant_collector (2x2x1 map, 4-entry FIFO).
module tb_output_requant_collector;

    logic               clk, rst, start, cfg_relu, acc_valid, res_ready;
    logic [4:0]         cfg_shift;
    logic signed [31:0] acc_in;
    logic               acc_x, acc_y, acc_ch;
    logic               almost_full, res_valid, busy, done, overflow, protocol_err;
    logic signed [15:0] res_data;
    logic               res_x, res_y, res_ch;

    typedef struct packed {
        logic signed [15:0] data;
        logic [2:0]         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_accept = 0;
    int   done_cyc = 0;

    output_requant_collector #(
        .ACC_WIDTH(32), .OUT_WIDTH(16),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .acc_in(acc_in), .acc_valid(acc_valid), .acc_x(acc_x), .acc_y(acc_y), .acc_ch(acc_ch),
        .almost_full(almost_full), .res_data(res_data), .res_x(res_x), .res_y(res_y),
        .res_ch(res_ch), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .done(done), .overflow(overflow), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard on every accepted output and compare.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", $signed(res_data), mon_e.data);
                check("res_tag", {res_x, res_y, res_ch}, mon_e.tag);
            end
            last_accept = cyc;
        end
    end

    task automatic send(input logic signed [31:0] a, input logic [2:0] tag,
                        input logic keep, input logic signed [15:0] exp_d);
        exp_t t;
        acc_in    = a;
        {acc_x, acc_y, acc_ch} = tag;
        acc_valid = 1'b1;
        if (keep) begin
            t.data = exp_d;
            t.tag  = tag;
            sb.push_back(t);
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] sh, input logic relu);
        @(posedge clk); #1;
        cfg_shift = sh;
        cfg_relu  = relu;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        done_cyc = cyc;
        check("done_seen", seen, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        rst = 1'b1; start = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
        acc_in = '0; acc_valid = 1'b0; acc_x = 1'b0; acc_y = 1'b0; acc_ch = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;

        // Run 1: shift 4, latency check on the first value
        start_run(5'd4, 1'b0);
        send(296, 3'b101, 1'b1, 19);
        check("lat_t1_valid", res_valid, 0);
        @(posedge clk); #1;
        check("lat_t2_valid", res_valid, 1);
        check("lat_t2_data", res_data, 19);
        check("lat_t2_tag", {res_x, res_y, res_ch}, 3'b101);
        send(-296,    3'b010, 1'b1, -18);
        send(0,       3'b110, 1'b1, 0);
        send(1000000, 3'b011, 1'b1, 32767);
        wait_done(40);

        // Run 2: shift 3, negative rounding; a stray start mid-run must be ignored
        start_run(5'd3, 1'b0);
        send(-40, 3'b000, 1'b1, -5);
        cfg_shift = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(40,      3'b100, 1'b1, 5);
        send(-100000, 3'b010, 1'b1, -12500);
        send(12,      3'b111, 1'b1, 2);
        wait_done(40);

        // Run 3: shift 3 with ReLU
        start_run(5'd3, 1'b1);
        send(-40, 3'b001, 1'b1, 0);
        send(40,  3'b010, 1'b1, 5);
        send(7,   3'b011, 1'b1, 1);
        send(-1,  3'b100, 1'b1, 0);
        wait_done(40);

        // Run 4: shift 0, saturation at both ends
        start_run(5'd0, 1'b0);
        send(32'sh7FFF_FFFF, 3'b000, 1'b1, 32767);
        send(32'sh8000_0000, 3'b111, 1'b1, -32768);
        send(5,  3'b101, 1'b1, 5);
        send(-5, 3'b010, 1'b1, -5);
        wait_done(40);

        // Run 5: shift 31, rounding add needs the guard bit
        start_run(5'd31, 1'b0);
        send(32'sh7FFF_FFFF, 3'b001, 1'b1, 1);
        send(32'sh8000_0000, 3'b110, 1'b1, -1);
        send(32'sh4000_0000, 3'b011, 1'b1, 1);
        send(32'sh3FFF_FFFF, 3'b100, 1'b1, 0);
        wait_done(40);

        // Run 6: backpressure, almost_full and overflow
        res_ready = 1'b0;
        start_run(5'd0, 1'b0);
        check("af_idle", almost_full, 0);
        send(1, 3'b000, 1'b1, 1);
        check("af_one_inflight", almost_full, 0);
        send(2, 3'b001, 1'b1, 2);
        check("af_two_inflight", almost_full, 1);
        send(3, 3'b010, 1'b1, 3);
        send(4, 3'b011, 1'b1, 4);
        send(5, 3'b100, 1'b0, 0);
        check("ovf_before_drop", overflow, 0);
        @(posedge clk); #1;
        check("ovf_after_drop", overflow, 1);
        check("ovf_head_data", res_data, 1);
        res_ready = 1'b1;
        wait_done(40);

        // Run 7: irregular res_ready, done/busy timing
        @(posedge clk); #1;
        res_ready = 1'b0;
        start_run(5'd1, 1'b0);
        send(3,  3'b000, 1'b1, 2);
        send(-3, 3'b110, 1'b1, -1);
        send(100, 3'b101, 1'b1, 50);
        send(-7, 3'b011, 1'b1, -3);
        @(posedge clk); #1;
        pat = 10'b10_0011_0010;
        for (int i = 0; i < 10; i++) begin
            res_ready = pat[i];
            @(posedge clk); #1;
        end
        wait_done(20);
        res_ready = 1'b1;
        check("done_one_after_accept", done_cyc - last_accept, 1);
        check("busy_during_done", busy, 1);
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("busy_fall", busy, 0);
        check("no_protocol_err_yet", protocol_err, 0);

        // Abort mid-run with 3 queued entries, then acc_valid in IDLE
        @(posedge clk); #1;
        res_ready = 1'b0;
        start_run(5'd2, 1'b0);
        send(10, 3'b001, 1'b0, 0);
        send(20, 3'b010, 1'b0, 0);
        send(30, 3'b011, 1'b0, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("pre_abort_valid", res_valid, 1);
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_res_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_overflow", overflow, 0);
        check("abort_protocol_err", protocol_err, 0);
        check("abort_res_data", res_data, 0);
        res_ready = 1'b1;
        send(7, 3'b111, 1'b0, 0);
        check("idle_protocol_err", protocol_err, 1);
        @(posedge clk); #1;
        check("idle_not_captured", res_valid, 0);
        check("sb_final_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
